// File: rtl/imm_extend_pipe.sv
// Immediate extender with a one-result output register and a one-entry skid buffer.
// Optional feature: define IMM_EXT_LUI_EN to build the load-upper mode (mode 10).
module imm_extend_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] extend_o,
    output logic [1:0]       count_o
);

    localparam int unsigned EXT_W = OUT_W - IN_W;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [OUT_W-1:0]   skid_q, skid_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [OUT_W-1:0]   sext_c;
    logic [OUT_W-1:0]   ext_c;
    logic               xfer_in_c;
    logic               xfer_out_c;

    // Extension of the raw immediate according to the requested mode.
    always_comb begin
        sext_c = {{EXT_W{data_i[IN_W-1]}}, data_i};
        ext_c  = sext_c;
        case (mode_i)
            2'b00: ext_c = sext_c;
            2'b01: ext_c = {{EXT_W{1'b0}}, data_i};
`ifdef IMM_EXT_LUI_EN
            2'b10: ext_c = {data_i, {EXT_W{1'b0}}};
`else
            2'b10: ext_c = sext_c;
`endif
            2'b11: ext_c = sext_c << 2;
            default: ext_c = sext_c;
        endcase
    end

    assign xfer_in_c  = valid_i && ready_q;
    assign xfer_out_c = valid_q && ready_i;

    // Next-state: output register refills from the skid on drain; flush wins over everything.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (xfer_in_c) begin
                    out_d   = ext_c;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (xfer_in_c && xfer_out_c) begin
                    out_d = ext_c;
                end else if (xfer_in_c) begin
                    skid_d  = ext_c;
                    state_d = ST_FULL;
                end else if (xfer_out_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer_out_c) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (flush_i) begin
            state_d = ST_EMPTY;
        end

        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_FULL);
        count_d = CNT_W'(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            count_q <= count_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign extend_o = out_q;
    assign count_o  = count_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_i;
    logic [1:0]  mode_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] extend_o;
    logic [1:0]  count_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mq[$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (flush_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .mode_i   (mode_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .extend_o (extend_o),
        .count_o  (count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_ext(input logic [1:0] m, input logic [15:0] d);
        longint s;
        s = longint'($signed(d));
        case (m)
            2'd0: return 32'(s);
            2'd1: return 32'(d);
`ifdef IMM_EXT_LUI_EN
            2'd2: return 32'(d) * 32'h0001_0000;
`else
            2'd2: return 32'(s);
`endif
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock: inputs were set after the previous negedge; model follows the edge.
    task automatic step();
        bit do_out;
        bit do_in;
        @(posedge clk);
        if (flush_i) begin
            mq.delete();
        end else begin
            do_out = (mq.size() > 0) && ready_i;
            do_in  = valid_i && (mq.size() != 2);
            if (do_out) void'(mq.pop_front());
            if (do_in) mq.push_back(model_ext(mode_i, data_i));
        end
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 64'(count_o), 64'(mq.size()));
        chk({tag, ".valid"}, 64'(valid_o), 64'(mq.size() > 0));
        chk({tag, ".ready"}, 64'(ready_o), 64'(mq.size() != 2));
        if (mq.size() > 0) chk({tag, ".ext"}, 64'(extend_o), 64'(mq[0]));
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] got[$];
    logic [31:0] want[3];
    logic [15:0] abc[3];
    int          seen;

    initial begin
        vecs[0] = '{2'd0, 16'h8001, 32'hFFFF_8001};
        vecs[1] = '{2'd1, 16'hFFFE, 32'h0000_FFFE};
`ifdef IMM_EXT_LUI_EN
        vecs[2] = '{2'd2, 16'hFFFE, 32'hFFFE_0000};
        vecs[5] = '{2'd2, 16'h1234, 32'h1234_0000};
`else
        vecs[2] = '{2'd2, 16'hFFFE, 32'hFFFF_FFFE};
        vecs[5] = '{2'd2, 16'h1234, 32'h0000_1234};
`endif
        vecs[3] = '{2'd3, 16'hFFFE, 32'hFFFF_FFF8};
        vecs[4] = '{2'd0, 16'h7FFF, 32'h0000_7FFF};
        vecs[6] = '{2'd3, 16'h4001, 32'h0001_0004};
        vecs[7] = '{2'd1, 16'h8000, 32'h0000_8000};

        reset = 1'b0; flush_i = 0; valid_i = 0; data_i = '0; mode_i = '0; ready_i = 1;
        repeat (2) @(negedge clk);
        chk("reset.valid", 64'(valid_o), 64'd0);
        chk("reset.count", 64'(count_o), 64'd0);
        chk("reset.ready", 64'(ready_o), 64'd1);
        chk("reset.ext", 64'(extend_o), 64'd0);
        reset = 1'b1;

        // Single-transaction vectors, latency one cycle.
        for (int i = 0; i < 8; i++) begin
            valid_i = 1; mode_i = vecs[i].mode; data_i = vecs[i].data; ready_i = 1;
            step();
            valid_i = 0; mode_i = ~mode_i; data_i = ~data_i;
            chk($sformatf("vec%0d.ext", i), 64'(extend_o), 64'(vecs[i].exp));
            chk($sformatf("vec%0d.valid", i), 64'(valid_o), 64'd1);
            chk($sformatf("vec%0d.count", i), 64'(count_o), 64'd1);
            step();
            chk($sformatf("vec%0d.drain", i), 64'(count_o), 64'd0);
        end

        // Backpressure: A, B accepted, C refused until space frees.
        abc[0] = 16'hA00A; abc[1] = 16'hB00B; abc[2] = 16'hC00C;
        ready_i = 0; mode_i = 2'd1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1; data_i = abc[i];
            want[i] = model_ext(2'd1, abc[i]);
            step();
            check_model($sformatf("bp%0d", i));
        end
        chk("bp.full_count", 64'(count_o), 64'd2);
        chk("bp.full_ready", 64'(ready_o), 64'd0);
        chk("bp.held_ext", 64'(extend_o), 64'(want[0]));
        ready_i = 1;
        for (int c = 0; c < 10; c++) begin
            if (valid_i && ready_o) begin
                if (valid_o) got.push_back(extend_o);
                step();
                valid_i = 0;
            end else begin
                if (valid_o) got.push_back(extend_o);
                step();
            end
            check_model("bp.drain");
        end
        chk("bp.out_num", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("bp.order%0d", i), 64'(i < got.size() ? got[i] : 32'hDEAD_BEEF), 64'(want[i]));

        // Streaming at full rate.
        ready_i = 1; mode_i = 2'd0;
        for (int i = 0; i < 8; i++) begin
            valid_i = 1; data_i = 16'(16'h0100 + i * 16'h1111);
            step();
            chk($sformatf("stream%0d.valid", i), 64'(valid_o), 64'd1);
            chk($sformatf("stream%0d.count", i), 64'(count_o), 64'd1);
            chk($sformatf("stream%0d.ext", i), 64'(extend_o), 64'(model_ext(2'd0, data_i)));
        end
        valid_i = 0;
        step();
        check_model("stream.end");

        // Flush with a simultaneous offer while FULL.
        ready_i = 0; valid_i = 1; mode_i = 2'd1;
        data_i = 16'h1111; step();
        data_i = 16'h2222; step();
        chk("flush.pre_count", 64'(count_o), 64'd2);
        flush_i = 1; data_i = 16'h3333; step();
        flush_i = 0; valid_i = 0;
        chk("flush.count", 64'(count_o), 64'd0);
        chk("flush.valid", 64'(valid_o), 64'd0);
        chk("flush.ready", 64'(ready_o), 64'd1);
        ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("flush.quiet%0d", i), 64'(valid_o), 64'd0);
        end

        // Asynchronous reset between edges while FULL.
        ready_i = 0; valid_i = 1; mode_i = 2'd0;
        data_i = 16'h4444; step();
        data_i = 16'h5555; step();
        chk("areset.pre_count", 64'(count_o), 64'd2);
        valid_i = 0;
        #2 reset = 1'b0;
        #1;
        chk("areset.valid", 64'(valid_o), 64'd0);
        chk("areset.count", 64'(count_o), 64'd0);
        chk("areset.ready", 64'(ready_o), 64'd1);
        chk("areset.ext", 64'(extend_o), 64'd0);
        mq.delete();
        #1 reset = 1'b1;
        valid_i = 1; data_i = 16'hF00F; mode_i = 2'd3; ready_i = 1;
        step();
        valid_i = 0;
        chk("areset.first_ext", 64'(extend_o), 64'(32'hFFFF_C03C));
        chk("areset.first_count", 64'(count_o), 64'd1);
        step();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            flush_i = ($urandom_range(0, 15) == 0);
            data_i  = 16'($urandom);
            mode_i  = 2'($urandom);
            step();
            check_model("rand");
        end
        flush_i = 0; valid_i = 0; ready_i = 1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (valid_o) seen++;
        end
        chk("rand.drained", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL provide parameter IN_W, default 16, immediate input width in bits.
REQ-002 SHALL provide parameter OUT_W, default 32, extended output width; legal range OUT_W >= IN_W + 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port flush_i, input, 1, synchronous discard of all held entries.
REQ-006 SHALL have port valid_i, input, 1, upstream request valid.
REQ-007 SHALL have port ready_o, output, 1, block can accept a request this cycle.
REQ-008 SHALL have port data_i, input, IN_W, raw immediate field.
REQ-009 SHALL have port mode_i, input, 2, extension mode.
REQ-010 SHALL have port valid_o, output, 1, extend_o holds a result.
REQ-011 SHALL have port ready_i, input, 1, downstream accepts a result.
REQ-012 SHALL have port extend_o, output, OUT_W, extended immediate.
REQ-013 SHALL have port count_o, output, 2, entries held (0..2).

Function
REQ-014 Mode 00 SHALL sign-extend: data_i[IN_W-1] replicated into bits OUT_W-1..IN_W.
REQ-015 Mode 01 SHALL zero-extend: bits OUT_W-1..IN_W = 0.
REQ-016 Mode 10 SHALL load-upper: data_i in bits OUT_W-1..OUT_W-IN_W, lower bits 0 (when IMM_EXT_LUI_EN is defined; see REQ-030).
REQ-017 Mode 11 SHALL branch-offset: sign-extend, then shift left 2, truncated to OUT_W, bits 1..0 = 0.
REQ-018 Mode and data SHALL be sampled on the accepting edge; later changes do not affect a held result.
REQ-019 A transfer in SHALL occur when valid_i && ready_o; a transfer out SHALL occur when valid_o && ready_i.
REQ-020 Latency SHALL be exactly 1 cycle from accept to valid_o when the block is empty; throughput is 1 per cycle while ready_i = 1.
REQ-021 Storage SHALL be one output register plus one skid register; the skid is loaded only when a transfer in occurs, the output register is valid, and ready_i = 0.
REQ-022 States SHALL be EMPTY (count 0), ONE (count 1, output valid), and FULL (count 2, output and skid valid).
- EMPTY -> ONE on transfer in.
- ONE -> EMPTY on transfer out without transfer in.
- ONE -> FULL on transfer in without transfer out.
- FULL -> ONE on transfer out; the skid moves to the output register the same edge.
REQ-023 ready_o SHALL be a registered signal equal to (count_o != 2); it SHALL NOT depend combinationally on ready_i.
REQ-024 In FULL, valid_i SHALL be ignored (no accept, no overwrite).
REQ-025 Simultaneous transfer in and transfer out in ONE SHALL replace the output register with the new result; count stays 1.
REQ-026 While valid_o = 1 and ready_i = 0, extend_o SHALL be held stable.
REQ-027 flush_i SHALL take priority over all transfers: next state EMPTY, valid_o = 0, ready_o = 1, and an input offered that cycle is dropped.

Reset
REQ-028 Assertion of reset SHALL immediately force valid_o = 0, count_o = 0, ready_o = 1, extend_o = 0, state EMPTY, skid contents 0, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL discard held results; the first edge after deassertion SHALL accept a request normally.

Configuration
REQ-030 Macro IMM_EXT_LUI_EN SHALL control mode 10.
- Defined: mode 10 performs load-upper per REQ-016.
- Undefined: no load-upper logic is built, and mode 10 performs sign-extend identical to mode 00.

Verification
REQ-031 Reset, then mode 00 with data_i = 16'h8001, ready_i = 1 -> next cycle valid_o = 1, extend_o = 32'hFFFF8001, count_o = 1.
REQ-032 Modes 01, 10, 11 with data_i = 16'hFFFE -> extend_o = 32'h0000FFFE, 32'hFFFE0000 (32'hFFFFFFFE with the macro undefined), and 32'hFFFFFFF8, respectively.
REQ-033 Hold ready_i = 0 and offer 3 back-to-back requests A, B, C -> A and B are accepted, count_o = 2, ready_o = 0, C is not accepted; raise ready_i -> A, B, C emerge in order with no loss.
REQ-034 Stream 8 requests with ready_i = 1 -> 8 consecutive valid_o cycles, throughput 1 per cycle, count_o stays 1.
REQ-035 Reach FULL, then pulse flush_i together with valid_i = 1 -> next cycle count_o = 0, valid_o = 0, ready_o = 1, and the flushed input never appears.
REQ-036 Assert reset asynchronously between clock edges while FULL -> valid_o = 0 and count_o = 0 before the next edge.
